// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger game datapath.
//   - Grid geometry constants shared by the car movers, the frog controller
//     and the collision/level controller.
//   - Field widths for the position, level, lives and hold-counter buses.
//   - Game-state encoding, which is also the o_state debug/display code.
package frogger_pkg;

  // Geometry shared by every block that handles positions.
  localparam int CFG_NUM_LANES = 4;   // one car per lane
  localparam int CFG_GRID_W    = 20;  // valid x is 0..CFG_GRID_W-1
  localparam int CFG_LANE_ROW0 = 1;   // lane k occupies frog row CFG_LANE_ROW0+k
  localparam int CFG_GOAL_ROW  = 5;   // frog row that completes a level

  // Bus widths.
  localparam int CAR_X_W  = 5;
  localparam int FROG_Y_W = 4;
  localparam int LEVEL_W  = 7;
  localparam int LIVES_W  = 2;
  localparam int HOLD_W   = 25;

  // Game states; the numeric values are visible on o_state.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_HIT      = 3'd2,
    ST_LEVEL_UP = 3'd3,
    ST_OVER     = 3'd4
  } state_e;

endpackage

// File: rtl/collision_level_ctrl_if.sv
// Signal bundle between the collision/level controller and its neighbours.
//   slave  : the controller (consumes positions/start, drives game status)
//   master : the environment (car movers, frog controller, display logic)
// Inputs : i_frog_x, i_frog_y, i_car_x_flat (lane k at [5k+4:5k]), i_start
// Outputs: o_level, o_lives, o_hit, o_frog_reset, o_game_over, o_state
//
// Transfer semantics: there is no valid/ready pair. Every input is a level
// that is sampled on every rising clock edge; every output is a level that
// is valid for the whole cycle following the edge that produced it
// (o_hit is a single-cycle pulse).
interface collision_level_ctrl_if #(
  parameter int NUM_LANES = frogger_pkg::CFG_NUM_LANES
);
  import frogger_pkg::*;

  logic [CAR_X_W-1:0]           i_frog_x;
  logic [FROG_Y_W-1:0]          i_frog_y;
  logic [NUM_LANES*CAR_X_W-1:0] i_car_x_flat;
  logic                         i_start;
  logic [LEVEL_W-1:0]           o_level;
  logic [LIVES_W-1:0]           o_lives;
  logic                         o_hit;
  logic                         o_frog_reset;
  logic                         o_game_over;
  logic [2:0]                   o_state;

  modport slave (
    input  i_frog_x, i_frog_y, i_car_x_flat, i_start,
    output o_level, o_lives, o_hit, o_frog_reset, o_game_over, o_state
  );

  modport master (
    output i_frog_x, i_frog_y, i_car_x_flat, i_start,
    input  o_level, o_lives, o_hit, o_frog_reset, o_game_over, o_state
  );

endinterface

// File: rtl/lane_hit_cmp.sv
// Stage-1 compare: checks the frog position against every lane's car and
// against the goal row, and registers the two results.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   frog_x_i/_y_i   : frog column / row
//   car_x_flat_i    : lane k car column at [5k+4:5k]
//   hit_r_o         : registered "frog shares a cell with some car"
//   goal_r_o        : registered "frog is on the goal row"
// GRID_W must be at most 31 so that the x limit fits the 5-bit column bus.
module lane_hit_cmp
  import frogger_pkg::*;
#(
  parameter int NUM_LANES = CFG_NUM_LANES,
  parameter int GRID_W    = CFG_GRID_W,
  parameter int LANE_ROW0 = CFG_LANE_ROW0,
  parameter int GOAL_ROW  = CFG_GOAL_ROW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [CAR_X_W-1:0]           frog_x_i,
  input  logic [FROG_Y_W-1:0]          frog_y_i,
  input  logic [NUM_LANES*CAR_X_W-1:0] car_x_flat_i,
  output logic                         hit_r_o,
  output logic                         goal_r_o
);

  localparam logic [CAR_X_W-1:0]  X_LIMIT = CAR_X_W'(GRID_W);
  localparam logic [FROG_Y_W-1:0] GOAL_Y  = FROG_Y_W'(GOAL_ROW);

  logic [NUM_LANES-1:0] lane_hit;
  logic                 frog_x_ok;
  logic                 hit_d, goal_d;
  logic                 hit_q, goal_q;

  // Off-grid columns are "not on screen": they never collide, even when the
  // frog and the car carry the same out-of-range value.
  assign frog_x_ok = (frog_x_i < X_LIMIT);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [FROG_Y_W-1:0] ROW = FROG_Y_W'(LANE_ROW0 + k);
    logic [CAR_X_W-1:0] car_x;
    assign car_x       = car_x_flat_i[k*CAR_X_W +: CAR_X_W];
    assign lane_hit[k] = (frog_y_i == ROW) && frog_x_ok &&
                         (car_x < X_LIMIT) && (frog_x_i == car_x);
  end

  assign hit_d  = |lane_hit;
  assign goal_d = (frog_y_i == GOAL_Y);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q  <= 1'b0;
      goal_q <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      goal_q <= goal_d;
    end
  end

  assign hit_r_o  = hit_q;
  assign goal_r_o = goal_q;

endmodule

// File: rtl/collision_level_ctrl.sv
// Collision / level controller: single owner of the game state.
// Compares car positions with the frog (via lane_hit_cmp), takes lives on
// hits, advances the level on goal arrivals and produces the level bus that
// feeds every car mover.
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   bus (slave)    : frog/car positions and start in; level, lives, hit
//                    pulse, frog reset, game over and state code out
// Input change to o_hit is two clocks: one for the registered compare, one
// for the registered FSM output.
module collision_level_ctrl
  import frogger_pkg::*;
#(
  parameter int                NUM_LANES   = CFG_NUM_LANES,
  parameter int                GRID_W      = CFG_GRID_W,
  parameter int                LANE_ROW0   = CFG_LANE_ROW0,
  parameter int                GOAL_ROW    = CFG_GOAL_ROW,
  parameter int                LIVES_INIT  = 3,
  parameter int                MAX_LEVEL   = 16,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES = 25'd1000
) (
  input logic                  i_Clk,
  input logic                  i_Rst_n,
  collision_level_ctrl_if.slave bus
);

  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
  // Loading HOLD_CYCLES-1 and leaving at 0 keeps HIT/LEVEL_UP for exactly
  // HOLD_CYCLES clocks.
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_CYCLES - HOLD_W'(1);

  logic hit_r, goal_r;

  lane_hit_cmp #(
    .NUM_LANES (NUM_LANES),
    .GRID_W    (GRID_W),
    .LANE_ROW0 (LANE_ROW0),
    .GOAL_ROW  (GOAL_ROW)
  ) u_cmp (
    .clk_i        (i_Clk),
    .rst_ni       (i_Rst_n),
    .frog_x_i     (bus.i_frog_x),
    .frog_y_i     (bus.i_frog_y),
    .car_x_flat_i (bus.i_car_x_flat),
    .hit_r_o      (hit_r),
    .goal_r_o     (goal_r)
  );

  state_e               state_q, state_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [LEVEL_W-1:0]   level_inc;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 hit_q, hit_d;
  logic [HOLD_W-1:0]    cnt_q, cnt_d;

  assign level_inc = level_q + LEVEL_ONE;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      level_q <= LEVEL_ONE;
      lives_q <= LIVES_RST;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        // Start (or restart) reloads a fresh game in the same cycle.
        if (bus.i_start) begin
          state_d = ST_PLAY;
          level_d = LEVEL_ONE;
          lives_d = LIVES_RST;
        end
      end
      ST_PLAY: begin
        // A hit wins over a simultaneous goal arrival.
        if (hit_r) begin
          state_d = ST_HIT;
          hit_d   = 1'b1;
          lives_d = lives_q - LIVES_W'(1);
          cnt_d   = HOLD_LOAD;
        end else if (goal_r) begin
          state_d = ST_LEVEL_UP;
          level_d = (level_inc > MAX_LVL) ? MAX_LVL : level_inc;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HIT: begin
        // Compare results are ignored here, so a lingering collision during
        // the frog-reset hold cannot take a second life. Lives reach 0 only
        // on the way into this state, so the decrement never wraps.
        if (cnt_q == '0) begin
          state_d = (lives_q == '0) ? ST_OVER : ST_PLAY;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      ST_LEVEL_UP: begin
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_level      = level_q;
  assign bus.o_lives      = lives_q;
  assign bus.o_hit        = hit_q;
  assign bus.o_frog_reset = (state_q == ST_HIT) || (state_q == ST_LEVEL_UP);
  assign bus.o_game_over  = (state_q == ST_OVER);
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_collision_level_ctrl.sv
// Bench for collision_level_ctrl: directed game scenarios plus randomized
// frog/car placements, checked against a game-rule model held in the bench.
module tb_collision_level_ctrl;
  import frogger_pkg::*;

  localparam int HOLD  = 1000;
  localparam int HOLD2 = 8;
  localparam int LIVES0 = 3;
  localparam int MAXLV  = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  collision_level_ctrl_if #(.NUM_LANES(4)) bus ();
  collision_level_ctrl_if #(.NUM_LANES(4)) bus2 ();

  collision_level_ctrl dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  // Second instance whose goal row coincides with lane 1, so hit and goal
  // arrive in the same cycle.
  collision_level_ctrl #(
    .GOAL_ROW    (2),
    .HOLD_CYCLES (25'd8)
  ) dut2 (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus2)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_level;
  int exp_lives;
  logic [LIVES_W-1:0] exp_q[$];   // expected lives after each pending hit
  int cars[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game rule: a collision needs the frog on a lane's row, in the same
  // column as that lane's car, with both columns on the grid.
  function automatic bit model_hit(input int fx, input int fy);
    bit h = 1'b0;
    for (int k = 0; k < 4; k++)
      if (fy == CFG_LANE_ROW0 + k && fx == cars[k] && fx < CFG_GRID_W && cars[k] < CFG_GRID_W)
        h = 1'b1;
    return h;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int fx, input int fy);
    bus.i_frog_x = 5'(fx);
    bus.i_frog_y = 4'(fy);
    for (int k = 0; k < 4; k++) bus.i_car_x_flat[k*5 +: 5] = 5'(cars[k]);
  endtask

  // Called on the first cycle of a hold; returns its length and the number
  // of o_hit pulses seen after entry. Frog leaves the lanes at move_at.
  task automatic wait_hold(input int move_at, output int n, output int pulses);
    n = 1;
    pulses = 0;
    tick();
    while (bus.o_frog_reset && n < 3 * HOLD) begin
      n++;
      pulses += int'(bus.o_hit);
      if (n == move_at) drive(0, 0);
      tick();
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_level"}, 32'(bus.o_level), exp_level);
    check({tag, "_lives"}, 32'(bus.o_lives), exp_lives);
  endtask

  task automatic do_start(input string tag);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    exp_level = 1;
    exp_lives = LIVES0;
    check({tag, "_state"}, 32'(bus.o_state), 1);
    check_status(tag);
    check({tag, "_hit"}, 32'(bus.o_hit), 0);
    check({tag, "_over"}, 32'(bus.o_game_over), 0);
  endtask

  // After a hit is observed: run the hold and check where the game lands.
  task automatic finish_hit(input string tag, input int move_at);
    int n, p;
    if (move_at <= 1) drive(0, 0);
    wait_hold(move_at, n, p);
    check({tag, "_hold_len"}, 32'(n), HOLD);
    check({tag, "_extra_hits"}, 32'(p), 0);
    check({tag, "_after_state"}, 32'(bus.o_state), (exp_lives == 0) ? 4 : 1);
    check({tag, "_after_over"}, 32'(bus.o_game_over), (exp_lives == 0) ? 1 : 0);
    check_status({tag, "_after"});
  endtask

  task automatic observe_hit(input string tag);
    logic [LIVES_W-1:0] want;
    exp_lives--;
    exp_q.push_back(LIVES_W'(exp_lives));
    check({tag, "_pulse"}, 32'(bus.o_hit), 1);
    check({tag, "_state"}, 32'(bus.o_state), 2);
    check({tag, "_frog_reset"}, 32'(bus.o_frog_reset), 1);
    want = exp_q.pop_front();
    check({tag, "_lives"}, 32'(bus.o_lives), 32'(want));
    check({tag, "_level"}, 32'(bus.o_level), exp_level);
  endtask

  // Car in lane `lane` steps into the frog's column.
  task automatic do_hit(input int lane, input int fx, input int move_at, input string tag);
    cars[lane] = (fx + CFG_GRID_W - 1) % CFG_GRID_W;
    drive(fx, CFG_LANE_ROW0 + lane);
    tick();
    check({tag, "_pre"}, 32'(bus.o_hit), 0);
    cars[lane] = fx;
    drive(fx, CFG_LANE_ROW0 + lane);
    tick();
    check({tag, "_lat1"}, 32'(bus.o_hit), 0);
    tick();
    observe_hit(tag);
    finish_hit(tag, move_at);
  endtask

  task automatic observe_goal(input string tag);
    int n, p;
    exp_level = (exp_level + 1 > MAXLV) ? MAXLV : exp_level + 1;
    check({tag, "_state"}, 32'(bus.o_state), 3);
    check({tag, "_frog_reset"}, 32'(bus.o_frog_reset), 1);
    check({tag, "_hit"}, 32'(bus.o_hit), 0);
    check_status(tag);
    drive(0, 0);
    wait_hold(0, n, p);
    check({tag, "_hold_len"}, 32'(n), HOLD);
    check({tag, "_after_state"}, 32'(bus.o_state), 1);
  endtask

  task automatic do_goal(input string tag);
    drive(int'($urandom_range(0, 19)), CFG_GOAL_ROW);
    tick();
    tick();
    observe_goal(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fx, fy, n, p;
    bit h;
    for (int k = 0; k < 4; k++) cars[k] = 0;
    bus.i_start = 1'b0;
    bus2.i_start = 1'b0;
    bus2.i_frog_x = '0;
    bus2.i_frog_y = '0;
    bus2.i_car_x_flat = '0;
    drive(0, 0);
    exp_level = 1;
    exp_lives = LIVES0;

    // Reset values, held and after release with no start.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.o_state), 0);
    check_status("rst");
    check("rst_hit", 32'(bus.o_hit), 0);
    check("rst_frog_reset", 32'(bus.o_frog_reset), 0);
    check("rst_over", 32'(bus.o_game_over), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_state", 32'(bus.o_state), 0);

    do_start("start");

    // Frog at (7,2), lane-1 car moves 6 -> 7; collision lingers for half the hold.
    do_hit(1, 7, HOLD / 2, "hit1");

    // Seventeen goal arrivals: 2..16 then saturation.
    for (int i = 0; i < 17; i++) do_goal($sformatf("goal%0d", i));

    // Play out the remaining lives, restart, then three hits to game over.
    while (exp_lives > 0) do_hit(int'($urandom_range(0, 3)), int'($urandom_range(0, 19)), 1, "drain");
    do_start("restart1");
    for (int i = 0; i < 3; i++)
      do_hit(i, int'($urandom_range(0, 19)), 3, $sformatf("seq%0d", i));
    bus.i_start = 1'b1;   // must be ignored? no: OVER accepts start
    bus.i_start = 1'b0;
    tick();
    check("over_frozen_state", 32'(bus.o_state), 4);
    check_status("over_frozen");
    do_start("restart2");

    // Randomized placements against the rule model.
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 4; k++) cars[k] = int'($urandom_range(0, 31));
      fy = int'($urandom_range(0, 6));
      fx = int'($urandom_range(0, 31));
      if (fy >= 1 && fy <= 4 && $urandom_range(0, 1) == 1) fx = cars[fy - 1];
      h = model_hit(fx, fy);
      drive(fx, fy);
      tick();
      check("rnd_lat1", 32'(bus.o_hit), 0);
      tick();
      if (h) begin
        observe_hit("rnd_hit");
        finish_hit("rnd_hit", 1);
        if (exp_lives == 0) do_start("rnd_restart");
      end else if (fy == CFG_GOAL_ROW) begin
        observe_goal("rnd_goal");
      end else begin
        check("rnd_nohit", 32'(bus.o_hit), 0);
        check("rnd_state", 32'(bus.o_state), 1);
        check_status("rnd_quiet");
        drive(0, 0);
        tick();
      end
    end

    // Hit and goal in the same cycle (second instance, goal row = lane 1 row).
    bus2.i_start = 1'b1;
    tick();
    bus2.i_start = 1'b0;
    bus2.i_frog_x = 5'd7;
    bus2.i_frog_y = 4'd2;
    bus2.i_car_x_flat[9:5] = 5'd7;
    tick();
    tick();
    check("both_pulse", 32'(bus2.o_hit), 1);
    check("both_state", 32'(bus2.o_state), 2);
    check("both_level", 32'(bus2.o_level), 1);
    check("both_lives", 32'(bus2.o_lives), 2);
    n = 1;
    p = 0;
    tick();
    while (bus2.o_frog_reset && n < 100) begin
      n++;
      p += int'(bus2.o_hit);
      if (n == 4) bus2.i_frog_y = 4'd0;
      tick();
    end
    check("both_hold_len", 32'(n), HOLD2);
    check("both_extra_hits", 32'(p), 0);
    check("both_after_lives", 32'(bus2.o_lives), 2);
    check("both_after_level", 32'(bus2.o_level), 1);
    check("both_after_state", 32'(bus2.o_state), 1);

    // Asynchronous reset halfway through a LEVEL_UP hold.
    drive(3, CFG_GOAL_ROW);
    tick();
    tick();
    check("lvl_rst_entry", 32'(bus.o_state), 3);
    drive(0, 0);
    repeat (499) tick();
    check("lvl_rst_mid", 32'(bus.o_frog_reset), 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_level = 1;
    exp_lives = LIVES0;
    check("async_state", 32'(bus.o_state), 0);
    check_status("async");
    check("async_frog_reset", 32'(bus.o_frog_reset), 0);
    check("async_hit", 32'(bus.o_hit), 0);
    check("async_over", 32'(bus.o_game_over), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_start("post_rst");

    // Off-grid car and frog column in a lane row never collide.
    cars[0] = 25;
    drive(25, CFG_LANE_ROW0);
    tick();
    tick();
    check("offgrid_hit", 32'(bus.o_hit), 0);
    tick();
    check("offgrid_state", 32'(bus.o_state), 1);
    check("offgrid_lives", 32'(bus.o_lives), exp_lives);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
